// File: rtl/poly_derivative_unit_if.sv
// Term stream bundle for the power-rule differentiator: an input term
// channel (coefficient, exponent, last) and an output derivative channel,
// each with a valid/ready handshake.
interface poly_derivative_unit_if #(
    parameter int COEF_W = 8,
    parameter int EXP_W  = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [COEF_W-1:0]        in_coef;
    logic [EXP_W-1:0]         in_exp;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [COEF_W+EXP_W-1:0]  out_coef;
    logic [EXP_W-1:0]         out_exp;
    logic                     out_last;

    // Term producer / derivative consumer side
    modport master (
        output in_valid, in_coef, in_exp, in_last, out_ready,
        input  in_ready, out_valid, out_coef, out_exp, out_last
    );

    // Differentiator side
    modport slave (
        input  in_valid, in_coef, in_exp, in_last, out_ready,
        output in_ready, out_valid, out_coef, out_exp, out_last
    );
endinterface

// File: rtl/poly_derivative_unit.sv
// Streaming power-rule differentiator. Accepts one (a, n) term at a time and
// emits (a*n, n-1). The product is formed by an EXP_W-cycle shift-add loop.
// Constant terms are dropped unless they are the last term, in which case a
// null (0, 0, last) terminator is emitted so every polynomial ends in out_last.
module poly_derivative_unit #(
    parameter int COEF_W = 8,
    parameter int EXP_W  = 4,
    parameter int CNT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    poly_derivative_unit_if.slave term_if,
    output logic [CNT_W-1:0]     term_count,
    output logic                 busy
);
    localparam int ACC_W  = COEF_W + EXP_W;
    localparam int ITER_W = $clog2(EXP_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DROP = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  mcand_q, mcand_d;
    logic [EXP_W-1:0]  mplier_q, mplier_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              last_q, last_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ACC_W-1:0]  out_coef_q, out_coef_d;
    logic [EXP_W-1:0]  out_exp_q, out_exp_d;
    logic              out_last_q, out_last_d;
    logic [CNT_W-1:0]  term_count_q, term_count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              in_hs_s;
    logic              out_hs_s;

    // Handshake qualifiers; inputs are ignored whenever the matching side is not ready/valid
    always_comb begin
        in_hs_s  = term_if.in_valid & in_ready_q;
        out_hs_s = out_valid_q & term_if.out_ready;
    end

    // Next-state and datapath: term capture, shift-add multiply, output hold, term counting
    always_comb begin
        state_d      = state_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        acc_d        = acc_q;
        exp_d        = exp_q;
        last_d       = last_q;
        iter_d       = iter_q;
        out_coef_d   = out_coef_q;
        out_exp_d    = out_exp_q;
        out_last_d   = out_last_q;
        term_count_d = term_count_q;

        case (state_q)
            S_IDLE: begin
                if (in_hs_s) begin
                    mcand_d  = ACC_W'(term_if.in_coef);
                    mplier_d = term_if.in_exp;
                    acc_d    = {ACC_W{1'b0}};
                    exp_d    = term_if.in_exp;
                    last_d   = term_if.in_last;
                    iter_d   = {ITER_W{1'b0}};
                    if (term_if.in_exp != {EXP_W{1'b0}}) begin
                        state_d = S_MUL;
                    end else if (!term_if.in_last) begin
                        // d/dx of a constant is zero: nothing to emit
                        state_d = S_DROP;
                    end else begin
                        // Constant last term still has to close the polynomial
                        state_d    = S_OUT;
                        out_coef_d = {ACC_W{1'b0}};
                        out_exp_d  = {EXP_W{1'b0}};
                        out_last_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[ACC_W-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[EXP_W-1:1]};
                iter_d   = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(EXP_W - 1)) begin
                    // Final iteration: publish the completed product
                    state_d    = S_OUT;
                    out_coef_d = acc_d;
                    out_exp_d  = exp_q - EXP_W'(1);
                    out_last_d = last_q;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DROP: begin
                state_d = S_IDLE;
            end
            S_OUT: begin
                if (out_hs_s) begin
                    state_d = S_IDLE;
                    if (out_last_q) begin
                        term_count_d = {CNT_W{1'b0}};
                    end else begin
                        term_count_d = term_count_q + CNT_W'(1);
                    end
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they are glitch-free flop outputs
    always_comb begin
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d != S_IDLE);
    end

    // State and datapath registers; reset discards any in-flight term
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mcand_q      <= {ACC_W{1'b0}};
            mplier_q     <= {EXP_W{1'b0}};
            acc_q        <= {ACC_W{1'b0}};
            exp_q        <= {EXP_W{1'b0}};
            last_q       <= 1'b0;
            iter_q       <= {ITER_W{1'b0}};
            out_coef_q   <= {ACC_W{1'b0}};
            out_exp_q    <= {EXP_W{1'b0}};
            out_last_q   <= 1'b0;
            term_count_q <= {CNT_W{1'b0}};
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            acc_q        <= acc_d;
            exp_q        <= exp_d;
            last_q       <= last_d;
            iter_q       <= iter_d;
            out_coef_q   <= out_coef_d;
            out_exp_q    <= out_exp_d;
            out_last_q   <= out_last_d;
            term_count_q <= term_count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Output drive
    always_comb begin
        term_if.in_ready  = in_ready_q;
        term_if.out_valid = out_valid_q;
        term_if.out_coef  = out_coef_q;
        term_if.out_exp   = out_exp_q;
        term_if.out_last  = out_last_q;
        term_count        = term_count_q;
        busy              = busy_q;
    end
endmodule

// File: tb/tb_poly_derivative_unit.sv
// Directed bench for poly_derivative_unit: hand-computed derivative terms,
// latency, backpressure hold, constant drop, null terminator and mid-multiply reset.
module tb_poly_derivative_unit;
    localparam int COEF_W = 8;
    localparam int EXP_W  = 4;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] term_count;
    logic             busy;
    int               checks_s = 0;
    int               errors_s = 0;

    poly_derivative_unit_if #(.COEF_W(COEF_W), .EXP_W(EXP_W)) term_if ();

    poly_derivative_unit #(.COEF_W(COEF_W), .EXP_W(EXP_W), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .term_if    (term_if),
        .term_count (term_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_s++;
        if (got !== exp) begin
            errors_s++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer a term; returns right after the accepting edge (+1)
    task automatic send_term(input logic [7:0] coef, input logic [3:0] ex, input logic last);
        int n;
        term_if.in_valid = 1'b1;
        term_if.in_coef  = coef;
        term_if.in_exp   = ex;
        term_if.in_last  = last;
        n = 0;
        while (!term_if.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check_value("send_in_ready", {31'd0, term_if.in_ready}, 32'd1);
        @(posedge clk); #1;
        term_if.in_valid = 1'b0;
    endtask

    // Wait for a derivative term (out_ready assumed 1), check it and the count after handshake.
    // lat = edges after the accepting edge until out_valid is seen (-1 skips).
    task automatic expect_term(input string tag, input int coef, input int ex, input int last,
                               input int lat, input int cnt_after);
        int n;
        n = 0;
        while (!term_if.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_value({tag, "_valid"}, {31'd0, term_if.out_valid}, 32'd1);
        if (lat >= 0) check_value({tag, "_lat"}, n, lat);
        check_value({tag, "_coef"}, {20'd0, term_if.out_coef}, coef);
        check_value({tag, "_exp"}, {28'd0, term_if.out_exp}, ex);
        check_value({tag, "_last"}, {31'd0, term_if.out_last}, last);
        check_value({tag, "_inrdy"}, {31'd0, term_if.in_ready}, 32'd0);
        @(posedge clk); #1;
        check_value({tag, "_vld_after"}, {31'd0, term_if.out_valid}, 32'd0);
        check_value({tag, "_cnt"}, {28'd0, term_count}, cnt_after);
    endtask

    initial begin
        rst               = 1'b1;
        term_if.in_valid  = 1'b0;
        term_if.in_coef   = 8'd0;
        term_if.in_exp    = 4'd0;
        term_if.in_last   = 1'b0;
        term_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_in_ready", {31'd0, term_if.in_ready}, 32'd1);
        check_value("rst_out_valid", {31'd0, term_if.out_valid}, 32'd0);
        check_value("rst_out_coef", {20'd0, term_if.out_coef}, 32'd0);
        check_value("rst_out_exp", {28'd0, term_if.out_exp}, 32'd0);
        check_value("rst_out_last", {31'd0, term_if.out_last}, 32'd0);
        check_value("rst_count", {28'd0, term_count}, 32'd0);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 3x^4 -> 12x^3; accept edge plus four MUL edges = 5 cycles
        send_term(8'd3, 4'd4, 1'b1);
        check_value("t1_busy", {31'd0, busy}, 32'd1);
        expect_term("t1", 12, 3, 1, 4, 0);

        // 5x^2 + 7x + 9 -> (10,1,0), (7,0,0), null (0,0,1)
        send_term(8'd5, 4'd2, 1'b0);
        expect_term("t2a", 10, 1, 0, 4, 1);
        send_term(8'd7, 4'd1, 1'b0);
        expect_term("t2b", 7, 0, 0, 4, 2);
        send_term(8'd9, 4'd0, 1'b1);
        expect_term("t2c", 0, 0, 1, 0, 0);

        // Max operands: 255*15 = 3825, no truncation
        send_term(8'd255, 4'd15, 1'b1);
        expect_term("t3", 3825, 14, 1, 4, 0);

        // Zero coefficient still yields a term
        send_term(8'd0, 4'd3, 1'b1);
        expect_term("t3z", 0, 2, 1, 4, 0);

        // Backpressure: 6x^2 non-last held for 10 cycles while junk is offered on input
        term_if.out_ready = 1'b0;
        send_term(8'd6, 4'd2, 1'b0);
        term_if.in_valid = 1'b1;
        term_if.in_coef  = 8'd99;
        term_if.in_exp   = 4'd7;
        term_if.in_last  = 1'b1;
        for (int i = 0; i < 60 && !term_if.out_valid; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 10; i++) begin
            check_value("bp_valid", {31'd0, term_if.out_valid}, 32'd1);
            check_value("bp_coef", {20'd0, term_if.out_coef}, 32'd12);
            check_value("bp_exp", {28'd0, term_if.out_exp}, 32'd1);
            check_value("bp_last", {31'd0, term_if.out_last}, 32'd0);
            check_value("bp_inrdy", {31'd0, term_if.in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        term_if.in_valid  = 1'b0;
        term_if.out_ready = 1'b1;
        @(posedge clk); #1;
        check_value("bp_vld_after", {31'd0, term_if.out_valid}, 32'd0);
        check_value("bp_cnt", {28'd0, term_count}, 32'd1);

        // Constant non-last term is dropped after one DROP cycle
        send_term(8'd4, 4'd0, 1'b0);
        check_value("drop_busy", {31'd0, busy}, 32'd1);
        check_value("drop_inrdy", {31'd0, term_if.in_ready}, 32'd0);
        check_value("drop_valid", {31'd0, term_if.out_valid}, 32'd0);
        @(posedge clk); #1;
        check_value("drop_idle_busy", {31'd0, busy}, 32'd0);
        check_value("drop_idle_inrdy", {31'd0, term_if.in_ready}, 32'd1);
        check_value("drop_idle_valid", {31'd0, term_if.out_valid}, 32'd0);
        check_value("drop_cnt", {28'd0, term_count}, 32'd1);
        send_term(8'd2, 4'd1, 1'b1);
        expect_term("t5", 2, 0, 1, 4, 0);

        // Reset in the 2nd MUL cycle of 6x^3, with a nonzero count and held output
        send_term(8'd1, 4'd1, 1'b0);
        expect_term("t6pre", 1, 0, 0, 4, 1);
        send_term(8'd6, 4'd3, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_value("mrst_in_ready", {31'd0, term_if.in_ready}, 32'd1);
        check_value("mrst_out_valid", {31'd0, term_if.out_valid}, 32'd0);
        check_value("mrst_out_coef", {20'd0, term_if.out_coef}, 32'd0);
        check_value("mrst_out_exp", {28'd0, term_if.out_exp}, 32'd0);
        check_value("mrst_out_last", {31'd0, term_if.out_last}, 32'd0);
        check_value("mrst_count", {28'd0, term_count}, 32'd0);
        check_value("mrst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_value("mrst_no_stale", {31'd0, term_if.out_valid}, 32'd0);
        send_term(8'd1, 4'd1, 1'b1);
        expect_term("t6", 1, 0, 1, 4, 0);

        $display("CHECKS %0d ERRORS %0d", checks_s, errors_s);
        $finish;
    end
endmodule
